// File: rtl/k2red_mul_feed.sv
// Elastic pipelined LOGQ x LOGQ unsigned multiplier feeding the k2red C input.
// Optional sideband tag path enabled by defining K2RED_MUL_FEED_TAG_EN.
module k2red_mul_feed #(
  parameter int LOGQ   = 60,
  parameter int STAGES = 3,
  parameter int TAGW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOGQ-1:0]   in_A,
  input  logic [LOGQ-1:0]   in_B,
`ifdef K2RED_MUL_FEED_TAG_EN
  input  logic [TAGW-1:0]   in_tag,
  output logic [TAGW-1:0]   out_tag,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*LOGQ-1:0] C,
  output logic              busy
);

  localparam int LOGC = 2 * LOGQ;

  generate
    if (STAGES < 2 || STAGES > 6 || TAGW < 1) begin : g_bad_cfg
      $error("k2red_mul_feed: STAGES must be 2..6 and TAGW >= 1");
    end
  endgenerate

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES:0]   rdy;
  logic [LOGQ-1:0]   a_q, a_d, b_q, b_d;
  logic [LOGC-1:0]   prod;
  logic [LOGC-1:0]   p_q [1:STAGES-1];
  logic [LOGC-1:0]   p_d [1:STAGES-1];
`ifdef K2RED_MUL_FEED_TAG_EN
  logic [TAGW-1:0]   tag_q [0:STAGES-1];
  logic [TAGW-1:0]   tag_d [0:STAGES-1];
`endif

  assign prod = {{LOGQ{1'b0}}, a_q} * {{LOGQ{1'b0}}, b_q};

  // rdy[s]: stage s may load this cycle because it is empty or its occupant moves on.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy[s] = ~v_q[s] | rdy[s+1];
    end

    v_d    = v_q;
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    if (rdy[0]) begin
      v_d[0] = in_valid;
      a_d    = in_A;
      b_d    = in_B;
    end
    if (rdy[1]) begin
      v_d[1] = v_q[0];
      p_d[1] = prod;
    end
    for (int s = 2; s < STAGES; s++) begin
      if (rdy[s]) begin
        v_d[s] = v_q[s-1];
        p_d[s] = p_q[s-1];
      end
    end

`ifdef K2RED_MUL_FEED_TAG_EN
    tag_d = tag_q;
    if (rdy[0]) tag_d[0] = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      if (rdy[s]) tag_d[s] = tag_q[s-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  // Data registers carry no reset; their contents only matter under a set valid bit.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    p_q <= p_d;
`ifdef K2RED_MUL_FEED_TAG_EN
    tag_q <= tag_d;
`endif
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign C         = p_q[STAGES-1];
  assign busy      = |v_q;
`ifdef K2RED_MUL_FEED_TAG_EN
  assign out_tag   = tag_q[STAGES-1];
`endif

endmodule

// File: tb/tb_k2red_mul_feed.sv
// Scoreboard bench for k2red_mul_feed: directed vectors, decoupled output monitor.
// Tag checking follows K2RED_MUL_FEED_TAG_EN.
module tb_k2red_mul_feed;

  localparam int LOGQ   = 60;
  localparam int STAGES = 3;
  localparam int TAGW   = 8;
  localparam int LOGC   = 2 * LOGQ;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [LOGQ-1:0] in_A      = '0;
  logic [LOGQ-1:0] in_B      = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LOGC-1:0] C;
  logic            busy;
`ifdef K2RED_MUL_FEED_TAG_EN
  logic [TAGW-1:0] in_tag    = '0;
  logic [TAGW-1:0] out_tag;
`endif

  typedef struct packed {
    logic [LOGC-1:0] c;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   passes     = 0;
  bit   rand_ready = 1'b0;

  k2red_mul_feed #(.LOGQ(LOGQ), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
`ifdef K2RED_MUL_FEED_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [LOGC-1:0] act,
                            input logic [LOGC-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_output: got C=%0h, expected no output", C);
      return;
    end
    e = sb_q.pop_front();
    checkValue("C", C, e.c);
`ifdef K2RED_MUL_FEED_TAG_EN
    checkValue("out_tag", {{(LOGC-TAGW){1'b0}}, out_tag}, {{(LOGC-TAGW){1'b0}}, e.tag});
`endif
  endtask

  // Drive one pair, wait (bounded) for acceptance, record the expected result.
  task automatic applyStimulus(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                               input logic [LOGC-1:0] exp_c, input logic [TAGW-1:0] tag,
                               output int stalls);
    exp_t e;
    stalls   = 0;
    in_valid = 1'b1;
    in_A     = a;
    in_B     = b;
`ifdef K2RED_MUL_FEED_TAG_EN
    in_tag   = tag;
`endif
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        $display("[TB] FAIL accept_timeout: in_ready stuck at 0, expected 1");
        break;
      end
    end
    if (in_ready) begin
      e.c   = exp_c;
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkValue({name, "_busy"}, busy, 0);
    checkValue({name, "_sb_empty"}, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) checkOutput();
    end
  end

  initial begin : ready_toggler
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int              st;
    int              total;
    int              accepted;
    logic [LOGQ-1:0] a, b;
    logic [LOGQ-1:0] ones;
    logic [LOGC-1:0] exp_c;
    logic [LOGC-1:0] c_hold;

    // T1: reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkValue("t1_out_valid", out_valid, 0);
    checkValue("t1_busy", busy, 0);
    checkValue("t1_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkValue("t1_idle_out_valid", out_valid, 0);
    checkValue("t1_idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // T2: latency with maximal operands, (2^60-1)^2 = 2^120 - 2^61 + 1
    out_ready = 1'b1;
    ones      = '1;
    exp_c     = ~120'd0 - ((120'd1 << 61) - 120'd1) + 120'd1;
    applyStimulus(ones, ones, exp_c, 8'h11, st);
    @(negedge clk);
    checkValue("t2_cycle1_out_valid", out_valid, 0);
    @(negedge clk);
    checkValue("t2_cycle2_out_valid", out_valid, 0);
    @(negedge clk);
    checkValue("t2_cycle3_out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // T3: back-to-back stream
    total = 0;
    for (int i = 0; i < 100; i++) begin
      a = {$urandom, $urandom} & {LOGQ{1'b1}};
      b = {$urandom, $urandom} & {LOGQ{1'b1}};
      exp_c = LOGC'(a) * LOGC'(b);
      applyStimulus(a, b, exp_c, 8'(i), st);
      total += st;
    end
    checkValue("t3_stalls", total, 0);
    repeat (STAGES + 1) @(negedge clk);
    checkValue("t3_sb_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;

    // T4: backpressure fills exactly STAGES, then pass-through on release
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    in_A      = 60'd1;
    in_B      = 60'd1000;
`ifdef K2RED_MUL_FEED_TAG_EN
    in_tag    = 8'h40;
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{c: LOGC'(in_A) * LOGC'(in_B), tag: 8'(8'h40 + accepted)});
        accepted++;
      end
      @(posedge clk);
      #1;
      in_A = 60'(accepted + 1);
      in_B = 60'(1000 + accepted);
`ifdef K2RED_MUL_FEED_TAG_EN
      in_tag = 8'(8'h40 + accepted);
`endif
    end
    checkValue("t4_accepted", accepted, STAGES);
    @(negedge clk);
    checkValue("t4_full_in_ready", in_ready, 0);
    checkValue("t4_full_out_valid", out_valid, 1);
    c_hold = C;
    repeat (2) @(negedge clk);
    checkValue("t4_C_held", C, c_hold);
    checkValue("t4_C_first", c_hold, 120'd1000);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkValue("t4_passthru_in_ready", in_ready, 1);
    if (in_ready) sb_q.push_back('{c: LOGC'(in_A) * LOGC'(in_B), tag: 8'(8'h40 + accepted)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("t4_drain");

    // T5: sparse input with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 60'(i * 3 + 1);
      b = 60'(i * 7 + 2);
      applyStimulus(a, b, LOGC'(a) * LOGC'(b), 8'(8'h80 + i), st);
      @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    drain("t5_drain");

    // T6: asynchronous reset with data in flight
    out_ready = 1'b0;
    applyStimulus(60'd11, 60'd13, 120'd143, 8'h01, st);
    applyStimulus(60'd17, 60'd19, 120'd323, 8'h02, st);
    applyStimulus(60'd23, 60'd29, 120'd667, 8'h03, st);
    checkValue("t6_pre_out_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkValue("t6_rst_out_valid", out_valid, 0);
    checkValue("t6_rst_busy", busy, 0);
    checkValue("t6_rst_in_ready", in_ready, 1);
    sb_q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(60'd7, 60'd9, 120'd63, 8'hA5, st);
    drain("t6_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
